if_stage: RTL

Instruction-fetch stage of the 16-bit pipelined CPU. It holds the PC and computes PC+2. It drives the instruction-memory address and captures the fetched instruction plus PC+2 into the IF/ID pipeline register that the decode stage consumes. It also handles hazard stalls, branch redirects, and a halt-opcode freeze.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 29 ++
 rtl/if_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: word size, special
// instruction encodings, the IF/ID payload layout and the fetch-state enum.
package cpu_pkg;

    localparam int                WORD_W      = 16;
    localparam logic [WORD_W-1:0] NOP_INSTR   = 16'h0000;
    localparam logic [3:0]        HALT_OPCODE = 4'hF;
    localparam logic [WORD_W-1:0] RESET_PC    = 16'h0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc_plus2;
        logic [WORD_W-1:0] instr;
    } ifid_t;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with flush/load/hold control and a valid bit.
// Flush wins over load; a flushed stage holds BUBBLE and reads as not valid.
module ifid_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q     <= BUBBLE;
            valid <= 1'b0;
        end else if (flush) begin
            q     <= BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+step adder, halt-freeze FSM and
// the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter int                  ADDR_W      = cpu_pkg::WORD_W,
    parameter int                  INSTR_W     = cpu_pkg::WORD_W,
    parameter logic [ADDR_W-1:0]   RESET_PC    = cpu_pkg::RESET_PC,
    parameter int                  PC_STEP     = 2,
    parameter logic [INSTR_W-1:0]  NOP_INSTR   = cpu_pkg::NOP_INSTR,
    parameter logic [3:0]          HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic [INSTR_W-1:0]          Instruction,
    output logic [ADDR_W-1:0]           PCOutput,
    output logic [ADDR_W-1:0]           IFAdderOutput,
    output logic [ADDR_W+INSTR_W-1:0]   IFID_Output,
    output logic                        ifid_valid,
    output logic                        halted
);

    import cpu_pkg::*;

    localparam logic [ADDR_W+INSTR_W-1:0] IFID_BUBBLE = {{ADDR_W{1'b0}}, NOP_INSTR};

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_plus;
    logic              is_halt;
    logic              ifid_load;
    logic              ifid_flush;

    // Wrap-around at the top of the address space is intentional and silent.
    assign pc_plus = pc + ADDR_W'(PC_STEP);
    assign is_halt = (Instruction[INSTR_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= next_pc;
        end
    end

    // Redirect beats stall beats halt; a halted stage keeps injecting bubbles.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (branch_taken) begin
            next_pc    = branch_target;
            ifid_flush = 1'b1;
            next_state = RUN;
        end else if (stall) begin
            next_pc = pc;
        end else if (state == RUN) begin
            next_pc   = pc_plus;
            ifid_load = 1'b1;
            if (is_halt) begin
                next_state = HALTED;
            end
        end else begin
            ifid_flush = 1'b1;
        end
    end

    ifid_reg #(
        .WIDTH  (ADDR_W + INSTR_W),
        .BUBBLE (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .d       ({pc_plus, Instruction}),
        .q       (IFID_Output),
        .valid   (ifid_valid)
    );

    assign PCOutput      = pc;
    assign IFAdderOutput = pc_plus;
    assign halted        = (state == HALTED);

endmodule
